// File: rtl/btn_debounce_fsm.sv
// btn_debounce_fsm: 2-flop synchronizer plus debounce FSM that turns a raw push-button into a clean level and press/release strobes.
// Long-press detection (LONG_HELD state, hold counter, long_pulse) is built only when BTN_LONG_PRESS_EN is defined.
module btn_debounce_fsm #(
    parameter int unsigned DB_CYCLES   = 540000,
    parameter int unsigned LONG_CYCLES = 27000000,
    parameter int unsigned ACTIVE_LOW  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int unsigned DB_W   = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);
    localparam logic REL_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] PRESS_WAIT   = 3'd1;
    localparam logic [2:0] PRESSED      = 3'd2;
    localparam logic [2:0] RELEASE_WAIT = 3'd3;
`ifdef BTN_LONG_PRESS_EN
    localparam logic [2:0] LONG_HELD    = 3'd4;

    localparam int unsigned LONG_W   = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES - 1);
`endif

    logic            sync1;
    logic            sync2;
    logic            pressed_s;

    logic [2:0]      state;
    logic [2:0]      state_nx;
    logic [DB_W-1:0] db_cnt;
    logic [DB_W-1:0] db_cnt_nx;
    logic            btn_level_nx;
    logic            press_nx;
    logic            release_nx;
`ifdef BTN_LONG_PRESS_EN
    logic [LONG_W-1:0] hold_cnt;
    logic [LONG_W-1:0] hold_cnt_nx;
    logic              long_done;
    logic              long_done_nx;
    logic              long_nx;
`else
    logic              unused_long_cfg;
    assign unused_long_cfg = (LONG_CYCLES != 0);
`endif

    // Synchronizer rests at the released pin level so reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= REL_LVL;
            sync2 <= REL_LVL;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    assign pressed_s = sync2 ^ REL_LVL;

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            db_cnt        <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
`ifdef BTN_LONG_PRESS_EN
            hold_cnt      <= '0;
            long_done     <= 1'b0;
            long_pulse    <= 1'b0;
`endif
        end else begin
            state         <= state_nx;
            db_cnt        <= db_cnt_nx;
            btn_level     <= btn_level_nx;
            press_pulse   <= press_nx;
            release_pulse <= release_nx;
`ifdef BTN_LONG_PRESS_EN
            hold_cnt      <= hold_cnt_nx;
            long_done     <= long_done_nx;
            long_pulse    <= long_nx;
`endif
        end
    end

`ifndef BTN_LONG_PRESS_EN
    assign long_pulse = 1'b0;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_nx     = state;
        db_cnt_nx    = db_cnt;
        btn_level_nx = btn_level;
        press_nx     = 1'b0;
        release_nx   = 1'b0;
`ifdef BTN_LONG_PRESS_EN
        hold_cnt_nx  = hold_cnt;
        long_done_nx = long_done;
        long_nx      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pressed_s) begin
                    state_nx  = PRESS_WAIT;
                    db_cnt_nx = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pressed_s) begin
                    state_nx = IDLE;
                end else if (db_cnt == DB_MAX) begin
                    state_nx     = PRESSED;
                    btn_level_nx = 1'b1;
                    press_nx     = 1'b1;
`ifdef BTN_LONG_PRESS_EN
                    hold_cnt_nx  = '0;
`endif
                end else begin
                    db_cnt_nx = db_cnt + DB_W'(1);
                end
            end
            PRESSED: begin
                if (!pressed_s) begin
                    state_nx  = RELEASE_WAIT;
                    db_cnt_nx = '0;
`ifdef BTN_LONG_PRESS_EN
                end else if (hold_cnt == LONG_MAX) begin
                    state_nx     = LONG_HELD;
                    long_nx      = 1'b1;
                    long_done_nx = 1'b1;
                end else begin
                    hold_cnt_nx = hold_cnt + LONG_W'(1);
`endif
                end
            end
`ifdef BTN_LONG_PRESS_EN
            LONG_HELD: begin
                if (!pressed_s) begin
                    state_nx  = RELEASE_WAIT;
                    db_cnt_nx = '0;
                end
            end
`endif
            RELEASE_WAIT: begin
                // A bounce back to pressed resumes the hold phase without re-announcing it.
                if (pressed_s) begin
`ifdef BTN_LONG_PRESS_EN
                    state_nx = long_done ? LONG_HELD : PRESSED;
`else
                    state_nx = PRESSED;
`endif
                end else if (db_cnt == DB_MAX) begin
                    state_nx     = IDLE;
                    btn_level_nx = 1'b0;
                    release_nx   = 1'b1;
`ifdef BTN_LONG_PRESS_EN
                    long_done_nx = 1'b0;
`endif
                end else begin
                    db_cnt_nx = db_cnt + DB_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
